// File: rtl/trap_ctrl.sv
// Serialising-instruction initiator for the M-mode CSR/trap path: drain, one strobe, flush + redirect.
// Optional drain watchdog enabled by defining TRAP_DRAIN_TIMEOUT_EN.
module trap_ctrl #(
  parameter int XLEN          = 32,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_ecall,
  input  logic            req_is_mret,
  input  logic            req_is_csr,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr_addr,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_zimm,
  input  logic [XLEN-1:0] req_pc,
  input  logic            older_empty,
  output logic            csr_access,
  output logic [2:0]      csr_funct3,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_src,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            do_ecall,
  output logic            do_mret,
  output logic [XLEN-1:0] cur_pc,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  output logic            stall,
  output logic            flush,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_data,
  output logic            timeout_err
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_e;

  state_e          state_q;
  logic            op_ecall_q, op_mret_q, op_csr_q;
  logic [XLEN-1:0] pc_q, src_q, redir_pc_q, rd_data_q;
  logic [2:0]      f3_q;
  logic [11:0]     addr_q;
  logic            rd_valid_q;

  logic            req_take;
  logic            drain_done;
  logic            timeout_hit;
  logic            in_commit;
  logic [XLEN-1:0] src_d;
  logic [XLEN-1:0] redir_pc_d;

  assign req_take = req_valid && (req_is_ecall || req_is_mret || req_is_csr);
  assign src_d    = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_zimm} : req_rs1_val;

  // Masking instead of slicing keeps mtvec's mode bits out of the target PC.
  always_comb begin
    if (op_ecall_q)     redir_pc_d = mtvec_in & ~XLEN'(3);
    else if (op_mret_q) redir_pc_d = mepc_in;
    else                redir_pc_d = pc_q + XLEN'(4);
  end

`ifdef TRAP_DRAIN_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       terr_q;
  assign timeout_hit = !older_empty && (cnt_q == 8'(DRAIN_TIMEOUT - 1));
  assign timeout_err = terr_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign drain_done = older_empty || timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_ecall_q <= 1'b0;
      op_mret_q  <= 1'b0;
      op_csr_q   <= 1'b0;
      pc_q       <= '0;
      src_q      <= '0;
      f3_q       <= '0;
      addr_q     <= '0;
      redir_pc_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef TRAP_DRAIN_TIMEOUT_EN
      cnt_q      <= '0;
      terr_q     <= 1'b0;
`endif
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_take) begin
            op_ecall_q <= req_is_ecall;
            op_mret_q  <= !req_is_ecall && req_is_mret;
            op_csr_q   <= !req_is_ecall && !req_is_mret && req_is_csr;
            pc_q       <= req_pc;
            f3_q       <= req_funct3;
            addr_q     <= req_csr_addr;
            src_q      <= src_d;
            state_q    <= DRAIN;
`ifdef TRAP_DRAIN_TIMEOUT_EN
            cnt_q      <= '0;
`endif
          end
        end
        DRAIN: begin
`ifdef TRAP_DRAIN_TIMEOUT_EN
          cnt_q <= cnt_q + 8'd1;
          if (timeout_hit) terr_q <= 1'b1;
`endif
          if (drain_done) state_q <= COMMIT;
        end
        COMMIT: begin
          redir_pc_q <= redir_pc_d;
          if (op_csr_q) begin
            rd_data_q  <= csr_rdata;
            rd_valid_q <= 1'b1;
          end
          state_q <= REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_commit      = (state_q == COMMIT);
  assign req_ready      = (state_q == IDLE);
  assign stall          = (state_q != IDLE);
  assign flush          = (state_q == REDIRECT);
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redir_pc_q;

  assign csr_access = in_commit && op_csr_q;
  assign csr_funct3 = csr_access ? f3_q   : '0;
  assign csr_addr   = csr_access ? addr_q : '0;
  assign csr_src    = csr_access ? src_q  : '0;
  assign do_ecall   = in_commit && op_ecall_q;
  assign do_mret    = in_commit && op_mret_q;
  assign cur_pc     = do_ecall ? pc_q : '0;

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomised bench for trap_ctrl against a transaction-level model, plus directed literal scenarios.
`timescale 1ns/1ps
module tb_trap_ctrl;
  localparam int XLEN = 32;
  localparam int TO   = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_is_ecall = 1'b0, req_is_mret = 1'b0, req_is_csr = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [11:0] req_csr_addr = '0;
  logic [31:0] req_rs1_val = '0, req_pc = '0, csr_rdata = '0, mtvec_in = '0, mepc_in = '0;
  logic [4:0]  req_zimm = '0;
  logic older_empty = 1'b1, redirect_ready = 1'b0;

  logic        req_ready, csr_access, do_ecall, do_mret, stall, flush, redirect_valid;
  logic        rd_valid, timeout_err;
  logic [2:0]  csr_funct3;
  logic [11:0] csr_addr;
  logic [31:0] csr_src, cur_pc, redirect_pc, rd_data;

  trap_ctrl #(.XLEN(XLEN), .DRAIN_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_ecall(req_is_ecall), .req_is_mret(req_is_mret), .req_is_csr(req_is_csr),
    .req_funct3(req_funct3), .req_csr_addr(req_csr_addr), .req_rs1_val(req_rs1_val),
    .req_zimm(req_zimm), .req_pc(req_pc), .older_empty(older_empty),
    .csr_access(csr_access), .csr_funct3(csr_funct3), .csr_addr(csr_addr), .csr_src(csr_src),
    .csr_rdata(csr_rdata), .do_ecall(do_ecall), .do_mret(do_mret), .cur_pc(cur_pc),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .rd_valid(rd_valid), .rd_data(rd_data), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: phase 0 idle, 1 waiting for drain, 2 strobe cycle, 3 redirect offered.
  // op 0 = ecall, 1 = mret, 2 = csr.
  int          m_ph = 0, m_op = 0, m_dcnt = 0;
  logic [31:0] m_pc = '0, m_src = '0, m_rpc = '0, m_rdd = '0;
  logic [2:0]  m_f3 = '0;
  logic [11:0] m_addr = '0;
  logic        m_rdv = 1'b0, m_terr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_op <= 0; m_dcnt <= 0; m_pc <= '0; m_src <= '0; m_rpc <= '0;
      m_rdd <= '0; m_f3 <= '0; m_addr <= '0; m_rdv <= 1'b0; m_terr <= 1'b0;
    end else begin
      m_rdv <= 1'b0;
      if (m_ph == 0) begin
        if (req_valid && (req_is_ecall || req_is_mret || req_is_csr)) begin
          m_op   <= req_is_ecall ? 0 : (req_is_mret ? 1 : 2);
          m_pc   <= req_pc;
          m_f3   <= req_funct3;
          m_addr <= req_csr_addr;
          m_src  <= req_funct3[2] ? 32'(req_zimm) : req_rs1_val;
          m_dcnt <= 0;
          m_ph   <= 1;
        end
      end else if (m_ph == 1) begin
        if (older_empty) m_ph <= 2;
`ifdef TRAP_DRAIN_TIMEOUT_EN
        else begin
          m_dcnt <= m_dcnt + 1;
          if (m_dcnt + 1 >= TO) begin m_terr <= 1'b1; m_ph <= 2; end
        end
`endif
      end else if (m_ph == 2) begin
        m_rpc <= (m_op == 0) ? (mtvec_in / 4) * 4 : (m_op == 1) ? mepc_in : m_pc + 32'd4;
        if (m_op == 2) begin m_rdv <= 1'b1; m_rdd <= csr_rdata; end
        m_ph <= 3;
      end else begin
        if (redirect_ready) m_ph <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic c, e;
      c = (m_ph == 2) && (m_op == 2);
      e = (m_ph == 2) && (m_op == 0);
      chk("req_ready", req_ready, m_ph == 0);
      chk("stall", stall, m_ph != 0);
      chk("flush", flush, m_ph == 3);
      chk("redirect_valid", redirect_valid, m_ph == 3);
      chk("redirect_pc", redirect_pc, m_rpc);
      chk("csr_access", csr_access, c);
      chk("csr_funct3", csr_funct3, c ? m_f3 : 3'd0);
      chk("csr_addr", csr_addr, c ? m_addr : 12'd0);
      chk("csr_src", csr_src, c ? m_src : 32'd0);
      chk("do_ecall", do_ecall, e);
      chk("cur_pc", cur_pc, e ? m_pc : 32'd0);
      chk("do_mret", do_mret, (m_ph == 2) && (m_op == 1));
      chk("rd_valid", rd_valid, m_rdv);
      chk("rd_data", rd_data, m_rdd);
      chk("timeout_err", timeout_err, m_terr);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic e, input logic m, input logic c, input logic [2:0] f3,
                       input logic [11:0] a, input logic [31:0] rs1, input logic [4:0] z,
                       input logic [31:0] pc);
    req_valid = 1'b1; req_is_ecall = e; req_is_mret = m; req_is_csr = c;
    req_funct3 = f3; req_csr_addr = a; req_rs1_val = rs1; req_zimm = z; req_pc = pc;
    cyc();
    req_valid = 1'b0; req_is_ecall = 1'b0; req_is_mret = 1'b0; req_is_csr = 1'b0;
  endtask

  initial begin
    int cnt;
    cyc();
    chk("reset_req_ready", req_ready, 1);
    chk("reset_stall", stall, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    chk_en = 1'b1;
    cyc();
    rst_n = 1'b1;
    cyc();

    // ECALL with immediate drain
    older_empty = 1'b1; mtvec_in = 32'h203; redirect_ready = 1'b0;
    issue(1, 0, 0, 3'd0, 12'h0, 32'h0, 5'd0, 32'h100);
    chk("ecall_drain_stall", stall, 1);
    chk("ecall_no_early_strobe", do_ecall, 0);
    cyc();
    chk("ecall_strobe_c2", do_ecall, 1);
    chk("ecall_cur_pc", cur_pc, 32'h100);
    cyc();
    chk("ecall_rv_c3", redirect_valid, 1);
    chk("ecall_redirect_pc", redirect_pc, 32'h200);
    chk("ecall_flush", flush, 1);
    cyc();
    chk("ecall_flush_hold", flush, 1);
    redirect_ready = 1'b1;
    cyc();
    chk("ecall_flush_drop", flush, 0);
    chk("ecall_idle_ready", req_ready, 1);
    redirect_ready = 1'b0;

    // MRET with back-pressured redirect
    mepc_in = 32'h104;
    issue(0, 1, 0, 3'd0, 12'h0, 32'h0, 5'd0, 32'h300);
    cyc();
    chk("mret_strobe", do_mret, 1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("mret_redirect_pc_stable", redirect_pc, 32'h104);
      chk("mret_stall_hold", stall, 1);
      cyc();
    end
    redirect_ready = 1'b1;
    chk("mret_redirect_pc_final", redirect_pc, 32'h104);
    cyc();
    chk("mret_idle_stall", stall, 0);
    chk("mret_idle_ready", req_ready, 1);
    redirect_ready = 1'b0;

    // CSRRSI using zimm source
    csr_rdata = 32'h88;
    issue(0, 0, 1, 3'b110, 12'h300, 32'hDEADBEEF, 5'd5, 32'h40);
    cyc();
    chk("csrrsi_access", csr_access, 1);
    chk("csrrsi_src", csr_src, 32'd5);
    chk("csrrsi_addr", csr_addr, 12'h300);
    chk("csrrsi_funct3", csr_funct3, 3'b110);
    cyc();
    chk("csrrsi_rd_valid", rd_valid, 1);
    chk("csrrsi_rd_data", rd_data, 32'h88);
    chk("csrrsi_redirect_pc", redirect_pc, 32'h44);
    redirect_ready = 1'b1;
    cyc();
    chk("csrrsi_rd_valid_pulse", rd_valid, 0);
    redirect_ready = 1'b0;

    // CSRRW held in drain for 6 cycles
    older_empty = 1'b0;
    issue(0, 0, 1, 3'b001, 12'h340, 32'h1234, 5'd0, 32'h80);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (csr_access) cnt++;
      cyc();
    end
    chk("drain_hold_no_strobe", cnt, 0);
    older_empty = 1'b1; redirect_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (csr_access) cnt++;
      cyc();
    end
    chk("drain_single_strobe", cnt, 1);
    redirect_ready = 1'b0;

    // PC wrap on refetch
    issue(0, 0, 1, 3'b010, 12'h341, 32'h1, 5'd0, 32'hFFFFFFFC);
    cyc(); cyc();
    chk("wrap_redirect_pc", redirect_pc, 32'h0);
    redirect_ready = 1'b1; cyc(); redirect_ready = 1'b0;

    // Reset while draining discards the ECALL
    older_empty = 1'b0;
    issue(1, 0, 0, 3'd0, 12'h0, 32'h0, 5'd0, 32'h500);
    cyc();
    rst_n = 1'b0; #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_do_ecall", do_ecall, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    cyc(); cyc();
    rst_n = 1'b1; older_empty = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (do_ecall) cnt++;
      cyc();
    end
    chk("rst_discard_no_ecall", cnt, 0);

`ifdef TRAP_DRAIN_TIMEOUT_EN
    older_empty = 1'b0;
    issue(1, 0, 0, 3'd0, 12'h0, 32'h0, 5'd0, 32'h600);
    cnt = 1;
    while (!do_ecall && cnt < 40) begin cyc(); cnt++; end
    chk("timeout_commit_cycle", cnt, TO + 1);
    chk("timeout_err_set", timeout_err, 1);
    older_empty = 1'b1; redirect_ready = 1'b1;
    cyc(); cyc();
    chk("timeout_err_sticky", timeout_err, 1);
    redirect_ready = 1'b0;
`else
    chk("timeout_err_tied", timeout_err, 0);
`endif

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid      = $urandom_range(0, 1);
      req_is_ecall   = ($urandom_range(0, 3) == 0);
      req_is_mret    = ($urandom_range(0, 3) == 0);
      req_is_csr     = ($urandom_range(0, 1) == 0);
      req_funct3     = 3'($urandom);
      req_csr_addr   = 12'($urandom);
      req_rs1_val    = $urandom;
      req_zimm       = 5'($urandom);
      req_pc         = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      older_empty    = ($urandom_range(0, 3) != 0);
      redirect_ready = $urandom_range(0, 1);
      csr_rdata      = $urandom;
      mtvec_in       = $urandom;
      mepc_in        = $urandom;
      rst_n          = ($urandom_range(0, 399) != 0);
      cyc();
    end
    rst_n = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
